// File: rtl/gnrc_gray_cnt.sv
// gnrc_gray_cnt
// N-bit up/down Gray-code counter with a registered binary shadow.
// The Gray output is intended to cross clock domains as a pointer, so on
// every count step exactly one Gray bit changes, including across the wrap.
// Clear and parallel load re-initialise the pointer and may change any
// number of bits. All outputs are registered; there is no combinational
// path from any input to any output.

module gnrc_gray_cnt #(
  parameter int N       = 8,
  parameter int RST_VAL = 0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [N-1:0] load_val_i,
  input  logic         en_i,
  input  logic         down_i,
  output logic [N-1:0] bin_o,
  output logic [N-1:0] gray_o,
  output logic         wrap_o
);

  // Binary value used by both reset and synchronous clear.
  localparam logic [N-1:0] RST_BIN = RST_VAL[N-1:0];

  // Largest representable count (all ones).
  localparam logic [N-1:0] MAX_BIN = '1;

  // Binary-to-Gray conversion: each Gray bit is the XOR of adjacent
  // binary bits, so neighbouring binary values differ in one Gray bit.
  function automatic logic [N-1:0] to_gray(input logic [N-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // One count step modulo 2^N in the requested direction.
  function automatic logic [N-1:0] count_step(input logic [N-1:0] b,
                                              input logic         down);
    logic [N-1:0] one;
    one    = '0;
    one[0] = 1'b1;
    return down ? (b - one) : (b + one);
  endfunction

  // A step wraps when it moves between the two ends of the range.
  // For N>=2 this only happens max->0 counting up or 0->max counting down;
  // for N=1 the two ends are adjacent, so every step is a wrap.
  function automatic logic is_wrap(input logic [N-1:0] cur,
                                   input logic [N-1:0] nxt);
    return ((cur == MAX_BIN) && (nxt == '0)) ||
           ((cur == '0) && (nxt == MAX_BIN));
  endfunction

  logic [N-1:0] bin_p0;
  logic [N-1:0] gray_p0;
  logic         wrap_p0;

  logic [N-1:0] bin_p1;
  logic [N-1:0] gray_p1;
  logic         wrap_p1;

  // ---- stage p0: next-state selection (clear > load > count > hold) ----
  // Next binary value, its Gray code and the wrap flag for this edge.
  always_comb begin
    bin_p0  = bin_p1;
    wrap_p0 = 1'b0;
    if (clr_i) begin
      bin_p0 = RST_BIN;
    end else if (load_i) begin
      bin_p0 = load_val_i;
    end else if (en_i) begin
      bin_p0  = count_step(bin_p1, down_i);
      wrap_p0 = is_wrap(bin_p1, bin_p0);
    end
    gray_p0 = to_gray(bin_p0);
  end

  // ---- stage p1: output registers ----
  // Binary, Gray and wrap registers all update on the same edge; reset
  // overrides every other input and cancels any pending wrap pulse.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      bin_p1  <= RST_BIN;
      gray_p1 <= to_gray(RST_BIN);
      wrap_p1 <= 1'b0;
    end else begin
      bin_p1  <= bin_p0;
      gray_p1 <= gray_p0;
      wrap_p1 <= wrap_p0;
    end
  end

  assign bin_o  = bin_p1;
  assign gray_o = gray_p1;
  assign wrap_o = wrap_p1;

endmodule

// File: tb/tb_gnrc_gray_cnt.sv
// tb_gnrc_gray_cnt
// Four counter instances with different widths and reset values, driven by
// directed and random stimulus. A value-level model (integer arithmetic)
// predicts every output and a single compare process checks each cycle;
// directed sequences carry hand-computed literal expectations.

module tb_gnrc_gray_cnt;

  logic clk;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instance k: 0 -> N=4 RST_VAL=0, 1 -> N=4 RST_VAL=5,
  //             2 -> N=8 RST_VAL=0, 3 -> N=1 RST_VAL=0
  function automatic int wid(input int k);
    case (k)
      0: return 4;
      1: return 4;
      2: return 8;
      default: return 1;
    endcase
  endfunction

  function automatic int rval(input int k);
    return (k == 1) ? 5 : 0;
  endfunction

  logic       rst_n [4];
  logic       clr   [4];
  logic       ld    [4];
  logic       en    [4];
  logic       dn    [4];
  logic [7:0] lv    [4];

  logic [3:0] b0, g0, b1, g1;
  logic [7:0] b2, g2;
  logic       b3, g3;
  logic       w0, w1, w2, w3;

  logic [7:0] obin  [4];
  logic [7:0] ogray [4];
  logic       owrap [4];

  gnrc_gray_cnt #(.N(4), .RST_VAL(0)) u0 (
    .clk_i(clk), .rst_ni(rst_n[0]), .clr_i(clr[0]), .load_i(ld[0]),
    .load_val_i(lv[0][3:0]), .en_i(en[0]), .down_i(dn[0]),
    .bin_o(b0), .gray_o(g0), .wrap_o(w0));

  gnrc_gray_cnt #(.N(4), .RST_VAL(5)) u1 (
    .clk_i(clk), .rst_ni(rst_n[1]), .clr_i(clr[1]), .load_i(ld[1]),
    .load_val_i(lv[1][3:0]), .en_i(en[1]), .down_i(dn[1]),
    .bin_o(b1), .gray_o(g1), .wrap_o(w1));

  gnrc_gray_cnt #(.N(8), .RST_VAL(0)) u2 (
    .clk_i(clk), .rst_ni(rst_n[2]), .clr_i(clr[2]), .load_i(ld[2]),
    .load_val_i(lv[2]), .en_i(en[2]), .down_i(dn[2]),
    .bin_o(b2), .gray_o(g2), .wrap_o(w2));

  gnrc_gray_cnt #(.N(1), .RST_VAL(0)) u3 (
    .clk_i(clk), .rst_ni(rst_n[3]), .clr_i(clr[3]), .load_i(ld[3]),
    .load_val_i(lv[3][0:0]), .en_i(en[3]), .down_i(dn[3]),
    .bin_o(b3), .gray_o(g3), .wrap_o(w3));

  always_comb begin
    obin[0]  = {4'b0, b0};  ogray[0] = {4'b0, g0};  owrap[0] = w0;
    obin[1]  = {4'b0, b1};  ogray[1] = {4'b0, g1};  owrap[1] = w1;
    obin[2]  = b2;          ogray[2] = g2;          owrap[2] = w2;
    obin[3]  = {7'b0, b3};  ogray[3] = {7'b0, g3};  owrap[3] = w3;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int  m_bin  [4];
  int  m_wrap [4];
  bit  m_vld  [4];
  bit  m_cnt  [4];

  function automatic int mgray(input int x);
    return x ^ (x >> 1);
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      int size;
      int nxt;
      size = 1 << wid(k);
      m_cnt[k] = 1'b0;
      if (rst_n[k] !== 1'b1) begin
        m_bin[k]  = rval(k);
        m_wrap[k] = 0;
        m_vld[k]  = 1'b1;
      end else if (clr[k]) begin
        m_bin[k]  = rval(k);
        m_wrap[k] = 0;
      end else if (ld[k]) begin
        m_bin[k]  = int'(lv[k]) % size;
        m_wrap[k] = 0;
      end else if (en[k]) begin
        nxt = dn[k] ? m_bin[k] - 1 : m_bin[k] + 1;
        nxt = (nxt + size) % size;
        // wrap: movement between the two ends of the range
        m_wrap[k] = ((m_bin[k] == size - 1 && nxt == 0) ||
                     (m_bin[k] == 0 && nxt == size - 1)) ? 1 : 0;
        m_bin[k]  = nxt;
        m_cnt[k]  = 1'b1;
      end else begin
        m_wrap[k] = 0;
      end
    end
  end

  // ---------------- compare process ----------------
  int p_gray [4];
  bit p_vld  [4];

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (m_vld[k]) begin
        chk($sformatf("bin[%0d]", k),  int'(obin[k]),  m_bin[k]);
        chk($sformatf("gray[%0d]", k), int'(ogray[k]), mgray(m_bin[k]));
        chk($sformatf("wrap[%0d]", k), int'(owrap[k]), m_wrap[k]);
        if (m_cnt[k] && p_vld[k])
          chk($sformatf("onebit[%0d]", k), $countones(ogray[k] ^ p_gray[k][7:0]), 1);
        p_gray[k] = int'(ogray[k]);
        p_vld[k]  = 1'b1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    for (int k = 0; k < 4; k++) begin
      rst_n[k] = 1'b1; clr[k] = 1'b0; ld[k] = 1'b0;
      en[k] = 1'b0; dn[k] = 1'b0; lv[k] = 8'h00;
    end
  endtask

  int gtab [16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};

  initial begin
    int cnt;
    int guard;
    idle_all();
    for (int k = 0; k < 4; k++) rst_n[k] = 1'b0;
    tick();
    tick();
    // reset state
    chk("rst_bin0", int'(obin[0]), 0);
    chk("rst_gray0", int'(ogray[0]), 0);
    chk("rst_wrap0", int'(owrap[0]), 0);
    chk("rst_bin1", int'(obin[1]), 5);
    chk("rst_gray1", int'(ogray[1]), 7);
    chk("rst_bin3", int'(obin[3]), 0);
    idle_all();

    // N=4 up-count through a full cycle
    en[0] = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk($sformatf("up_bin_%0d", i), int'(obin[0]), i % 16);
      chk($sformatf("up_gray_%0d", i), int'(ogray[0]), gtab[i % 16]);
      chk($sformatf("up_wrap_%0d", i), int'(owrap[0]), (i == 16) ? 1 : 0);
    end

    // N=4 down from 0
    dn[0] = 1'b1;
    tick();
    chk("dn_bin", int'(obin[0]), 15);
    chk("dn_gray", int'(ogray[0]), 8);
    chk("dn_wrap", int'(owrap[0]), 1);
    tick();
    chk("dn2_bin", int'(obin[0]), 14);
    chk("dn2_gray", int'(ogray[0]), 9);
    chk("dn2_wrap", int'(owrap[0]), 0);

    // load beats count
    dn[0] = 1'b0; ld[0] = 1'b1; lv[0] = 8'h0A;
    tick();
    chk("ld_bin", int'(obin[0]), 10);
    chk("ld_gray", int'(ogray[0]), 15);
    chk("ld_wrap", int'(owrap[0]), 0);
    ld[0] = 1'b0;
    tick();
    chk("ldc_bin", int'(obin[0]), 11);
    chk("ldc_gray", int'(ogray[0]), 14);
    en[0] = 1'b0;

    // clear beats load and count (RST_VAL=5)
    en[1] = 1'b1;
    tick(); tick(); tick();
    chk("pre_clr_bin", int'(obin[1]), 8);
    clr[1] = 1'b1; ld[1] = 1'b1; lv[1] = 8'h09;
    tick();
    chk("clr_bin", int'(obin[1]), 5);
    chk("clr_gray", int'(ogray[1]), 7);
    chk("clr_wrap", int'(owrap[1]), 0);
    clr[1] = 1'b0; ld[1] = 1'b0; en[1] = 1'b0;

    // N=8: count to 0xFF with random gaps, then reset while enabled
    cnt = 0;
    guard = 0;
    while (cnt < 255 && guard < 2000) begin
      en[2] = ($urandom % 3) != 0;
      tick();
      if (en[2]) cnt++;
      guard++;
    end
    en[2] = 1'b0;
    chk("n8_reached_ff", int'(obin[2]), 255);
    rst_n[2] = 1'b0; en[2] = 1'b1;
    tick();
    chk("n8_rst_bin", int'(obin[2]), 0);
    chk("n8_rst_gray", int'(ogray[2]), 0);
    chk("n8_rst_wrap", int'(owrap[2]), 0);
    rst_n[2] = 1'b1; en[2] = 1'b0;

    // N=1: every count step is a wrap
    en[3] = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk($sformatf("n1_bin_%0d", i), int'(obin[3]), i % 2);
      chk($sformatf("n1_gray_%0d", i), int'(ogray[3]), i % 2);
      chk($sformatf("n1_wrap_%0d", i), int'(owrap[3]), 1);
    end
    en[3] = 1'b0;

    // random phase, all instances
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 4; k++) begin
        rst_n[k] = ($urandom % 80) != 0;
        clr[k]   = ($urandom % 25) == 0;
        ld[k]    = ($urandom % 15) == 0;
        en[k]    = ($urandom % 5) != 0;
        dn[k]    = (c % 400 < 200) ? (($urandom % 6) == 0) : (($urandom % 6) != 0);
        lv[k]    = 8'($urandom);
      end
      tick();
    end
    idle_all();
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
